quad2pos: RTL and testbench
===========================

// Module: quad2pos
// PURPOSE
//  Quadrature decoder: turns a two-phase encoder (spinner/paddle on USER_IN[1:0], or a
//  joy2quad output) into a paddle position. Synchronises and glitch-filters A/B,
//  decodes x4 Gray transitions into +/-1 steps and accumulates a clamped or wrapping
//  position. Its activity flag drives the encoder-vs-joystick input mux.
// PARAMETERS
//  POS_W     8    position width, bits
//  POS_MIN   0    lower bound of pos
//  POS_MAX   255  upper bound of pos (POS_MIN < POS_MAX <= 2^POS_W-1)
//  POS_RST   128  pos value after reset / clr
//  WRAP      0    0: clamp at bounds; 1: wrap POS_MAX<->POS_MIN
//  INVERT    0    1: swap count direction
//  FILTER    4    cycles A/B must be stable before acceptance; 0 = bypass filter
//  IDLE_CYC  1200000  cycles without a valid step before active drops (0.1 s @ 12 MHz)
// PORTS
//  CLK      in   1      system clock (clk_12 domain)
//  Reset_n  in   1      async active-low reset
//  enc_a    in   1      encoder phase A, asynchronous
//  enc_b    in   1      encoder phase B, asynchronous
//  clr      in   1      sync clear: pos <= POS_RST
//  pos      out  POS_W  accumulated position
//  step     out  1      1-cycle pulse per accepted valid transition
//  dir      out  1      direction of last valid step (1 = up); holds between steps
//  limit    out  1      1-cycle pulse when a step is absorbed by a clamp (WRAP=0)
//  err      out  1      1-cycle pulse on illegal transition (both phases changed)
//  active   out  1      encoder recently moved
// BEHAVIOUR
//  Reset: pos=POS_RST; step=dir=limit=err=active=0; sync/filter regs=00; primed=0.
//  Sync: 2 flops per phase. Filter: counter per AB pair, restarts whenever synced AB
//   changes; when synced AB != accepted AB and has been stable FILTER cycles, accepted
//   AB <= synced AB. FILTER=0: accepted AB <= synced AB every cycle.
//  Latency: new level first sampled at edge N -> step/err high during cycle N+3+FILTER.
//  Decode (prev -> new accepted AB, AB = {a,b}):
//   00->01, 01->11, 11->10, 10->00 : up (+1);  reverse order : down (-1).
//   INVERT=1 swaps up/down. Both bits differ: err pulse, no step, pos/dir unchanged.
//  Priming: first acceptance after reset only loads prev AB; no step/err. (Pins
//   idle at 11 must not raise err at power-up.) clr does not unprime.
//  Position: up at POS_MAX -> WRAP ? POS_MIN : hold + limit; down at POS_MIN ->
//   WRAP ? POS_MAX : hold + limit. step and dir still assert on clamped steps.
//  clr coincident with a step: pos=POS_RST (clr wins); step/dir/limit still reported.
//  active: set on every step; idle counter reloads to IDLE_CYC on step, decrements
//   otherwise; active <= 0 the cycle the counter reaches 0. err never sets active.
//  Reset asserted mid-operation: all state returns to reset values asynchronously;
//   after release decoder re-primes (no spurious step/err from stale AB).
//  Max rate: one step per FILTER+1 cycles; faster input is dropped, never miscounted
//   except as err when two edges collapse into one acceptance.
// STRUCTURE
//  Package quad_pkg: typedef enum logic[1:0] {Q00,Q01,Q11,Q10} quad_t; function
//   quad_dir(prev,new) -> {valid,up,illegal}; shared with joy2quad for sequence order.
//  Sub-module quad_sync_filter (2-flop sync + stability counter, FILTER param),
//   instanced once on {enc_a,enc_b}. Decode, accumulator, idle timer inline.
// TESTING
//  1 Reset with pins at 11, release, no movement 100 cycles -> step=err=0, pos=128.
//  2 Drive 00,01,11,10,00 each held 10 cycles (FILTER=4) -> 4 step pulses, dir=1,
//    pos 128->132; reverse sequence -> pos back to 128, dir=0; each step at N+7.
//  3 Glitch: toggle A for 3 cycles then return -> no step, no err, pos unchanged.
//  4 Jump 00->11 held 10 cycles -> one err pulse, pos/dir unchanged, active unchanged.
//  5 WRAP=0 from pos=254, 3 up steps -> pos 255 then held, limit pulses twice;
//    WRAP=1 same -> 255, 0, 1, limit never.
//  6 clr on same cycle as an up step -> pos=128, step=1; then idle IDLE_CYC (set 50)
//    cycles -> active falls exactly 50 cycles after last step.

Source files
------------

// File: rtl/quad_pkg.sv
// Quadrature phase encoding and transition classification.
// Shared with joy2quad so both sides agree on the up-count sequence order.
package quad_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } qdir_t;

  // Up-count successor: 00 -> 01 -> 11 -> 10 -> 00
  function automatic quad_t quad_next(input quad_t q);
    quad_t r;
    case (q)
      Q00:     r = Q01;
      Q01:     r = Q11;
      Q11:     r = Q10;
      default: r = Q00;
    endcase
    return r;
  endfunction

  function automatic qdir_t quad_dir(input quad_t prev, input quad_t nxt);
    qdir_t r;
    r.up      = (nxt == quad_next(prev));
    r.valid   = r.up || (prev == quad_next(nxt));
    r.illegal = ((prev ^ nxt) == 2'b11);
    return r;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchroniser plus stability filter on the A/B pair; acc_vld pulses on each new accepted level.
// Latency: FILTER+2 cycles from first sample to acceptance; no backpressure, shorter pulses are discarded.
module quad_sync_filter #(
  parameter int FILTER = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [1:0] ab_dat,
  output logic [1:0] acc_dat,
  output logic       acc_vld
);

  localparam int CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

  logic [1:0]    s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 2'b00;
      s2      <= 2'b00;
      cnt     <= '0;
      acc_dat <= 2'b00;
      acc_vld <= 1'b0;
    end else begin
      s1      <= ab_dat;
      s2      <= s1;
      acc_vld <= 1'b0;
      // s2 takes a new value at this edge whenever s1 differs: restart the stability count
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if ((s2 != acc_dat) && ((FILTER == 0) || (cnt == CNT_MAX))) begin
        acc_dat <= s2;
        acc_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad2pos.sv
// Quadrature decoder: filtered A/B x4 Gray decode into a clamped or wrapping position with activity flag.
// Latency: pin change to step/err pulse is FILTER+3 cycles; no backpressure, edges faster than FILTER+1 cycles are dropped.
module quad2pos
  import quad_pkg::*;
#(
  parameter int POS_W    = 8,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 255,
  parameter int POS_RST  = 128,
  parameter int WRAP     = 0,
  parameter int INVERT   = 0,
  parameter int FILTER   = 4,
  parameter int IDLE_CYC = 1200000
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             limit,
  output logic             err,
  output logic             active
);

  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_RST = POS_W'(POS_RST);
  localparam int               IW    = (IDLE_CYC < 1) ? 1 : $clog2(IDLE_CYC + 1);
  localparam logic [IW-1:0]    IDLE_LD = IW'(IDLE_CYC);
  localparam logic             WRAP_EN = (WRAP != 0);
  localparam logic             INV_EN  = (INVERT != 0);

  logic [1:0]       acc_dat;
  logic             acc_vld;
  quad_t            prev_ab;
  logic             primed;
  logic [IW-1:0]    idle_cnt;
  qdir_t            qd;
  logic             up;
  logic             at_bound;
  logic             do_step;
  logic [POS_W-1:0] pos_nxt;

  quad_sync_filter #(.FILTER(FILTER)) u_filt (
    .clk_sys (CLK),
    .rst_n   (Reset_n),
    .ab_dat  ({enc_a, enc_b}),
    .acc_dat (acc_dat),
    .acc_vld (acc_vld)
  );

  always_comb begin
    qd       = quad_dir(prev_ab, quad_t'(acc_dat));
    up       = qd.up ^ INV_EN;
    do_step  = acc_vld && primed && qd.valid;
    at_bound = up ? (pos == P_MAX) : (pos == P_MIN);
    pos_nxt  = pos;
    if (!at_bound)
      pos_nxt = up ? pos + 1'b1 : pos - 1'b1;
    else if (WRAP_EN)
      pos_nxt = up ? P_MIN : P_MAX;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pos      <= P_RST;
      step     <= 1'b0;
      dir      <= 1'b0;
      limit    <= 1'b0;
      err      <= 1'b0;
      active   <= 1'b0;
      primed   <= 1'b0;
      prev_ab  <= Q00;
      idle_cnt <= '0;
    end else begin
      step  <= 1'b0;
      limit <= 1'b0;
      err   <= 1'b0;
      // First acceptance after reset only establishes the reference level
      if (acc_vld) begin
        prev_ab <= quad_t'(acc_dat);
        primed  <= 1'b1;
        if (primed && qd.illegal)
          err <= 1'b1;
      end
      if (do_step) begin
        step  <= 1'b1;
        dir   <= up;
        limit <= at_bound && !WRAP_EN;
      end
      if (clr)
        pos <= P_RST;
      else if (do_step)
        pos <= pos_nxt;
      if (do_step) begin
        idle_cnt <= IDLE_LD;
        active   <= 1'b1;
      end else if (idle_cnt != '0) begin
        idle_cnt <= idle_cnt - 1'b1;
        if (idle_cnt == IW'(1))
          active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad2pos.sv
// Scoreboard bench for quad2pos: stimulus pushes expected events, negedge monitors pop and compare.
module tb_quad2pos;

  typedef struct {
    logic       err;
    logic       limit;
    logic       dir;
    logic [7:0] pos;
    logic       active;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ea_a, ea_b, clr_a;
  logic       eb_a, eb_b, clr_b;
  logic [7:0] pos_a, pos_b;
  logic       step_a, dir_a, limit_a, err_a, active_a;
  logic       step_b, dir_b, limit_b, err_b, active_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   s_cyc;
  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(posedge clk) cyc <= cyc + 1;

  quad2pos #(.POS_W(8), .POS_MIN(0), .POS_MAX(255), .POS_RST(128), .WRAP(0),
             .INVERT(0), .FILTER(4), .IDLE_CYC(50)) dut (
    .CLK(clk), .Reset_n(rst_n), .enc_a(ea_a), .enc_b(ea_b), .clr(clr_a),
    .pos(pos_a), .step(step_a), .dir(dir_a), .limit(limit_a), .err(err_a), .active(active_a)
  );

  quad2pos #(.POS_W(8), .POS_MIN(0), .POS_MAX(255), .POS_RST(254), .WRAP(1),
             .INVERT(0), .FILTER(4), .IDLE_CYC(50)) dut_w (
    .CLK(clk), .Reset_n(rst_n), .enc_a(eb_a), .enc_b(eb_b), .clr(clr_b),
    .pos(pos_b), .step(step_b), .dir(dir_b), .limit(limit_b), .err(err_b), .active(active_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic chk_evt(input string nm, input bit have, input exp_t e,
                         input logic st, input logic er, input logic li,
                         input logic di, input logic ac, input logic [7:0] p);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s unexpected event at cyc=%0d step=%0b err=%0b limit=%0b pos=%0d",
               nm, cyc, st, er, li, p);
    end else if (st !== ~e.err || er !== e.err || li !== e.limit || di !== e.dir ||
                 ac !== e.active || p !== e.pos || cyc != e.cyc) begin
      n_bad++;
      $display("FAIL %s event: got cyc=%0d step=%0b err=%0b limit=%0b dir=%0b active=%0b pos=%0d; want cyc=%0d step=%0b err=%0b limit=%0b dir=%0b active=%0b pos=%0d",
               nm, cyc, st, er, li, di, ac, p, e.cyc, ~e.err, e.err, e.limit, e.dir, e.active, e.pos);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    bit   have;
    if (rst_n === 1'b1 && (step_a || err_a || limit_a)) begin
      have = (qa.size() != 0);
      e    = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0};
      if (have) e = qa.pop_front();
      chk_evt("dut_evt", have, e, step_a, err_a, limit_a, dir_a, active_a, pos_a);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    bit   have;
    if (rst_n === 1'b1 && (step_b || err_b || limit_b)) begin
      have = (qb.size() != 0);
      e    = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0};
      if (have) e = qb.pop_front();
      chk_evt("dutw_evt", have, e, step_b, err_b, limit_b, dir_b, active_b, pos_b);
    end
  end

  // Drive a new A/B level and expect its event 8 cycles later (sampled at edge +1, pulse after edge +8)
  task automatic move_a(input logic [1:0] ab, input logic e_err, input logic e_lim,
                        input logic e_dir, input logic [7:0] e_pos, input logic e_act,
                        input logic with_clr);
    exp_t e;
    @(posedge clk); #1;
    clr_a = 1'b0;
    {ea_a, ea_b} = ab;
    e = '{e_err, e_lim, e_dir, e_pos, e_act, cyc + 8};
    s_cyc = cyc + 8;
    qa.push_back(e);
    repeat (6) @(posedge clk);
    @(posedge clk); #1;
    clr_a = with_clr;
  endtask

  task automatic move_b(input logic [1:0] ab, input logic e_dir, input logic [7:0] e_pos);
    exp_t e;
    @(posedge clk); #1;
    {eb_a, eb_b} = ab;
    e = '{1'b0, 1'b0, e_dir, e_pos, 1'b1, cyc + 8};
    qb.push_back(e);
    repeat (7) @(posedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0;
    {ea_a, ea_b} = 2'b11;
    {eb_a, eb_b} = 2'b11;
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Power-up with pins idle at 11: priming only, no events
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_pos", pos_a, 128);
    chk("idle_step", step_a, 0);
    chk("idle_err", err_a, 0);
    chk("idle_dir", dir_a, 0);
    chk("idle_active", active_a, 0);
    chk("idle_posw", pos_b, 254);

    // Four up steps then four down steps
    move_a(2'b10, 0, 0, 1, 129, 1, 0);
    move_a(2'b00, 0, 0, 1, 130, 1, 0);
    move_a(2'b01, 0, 0, 1, 131, 1, 0);
    move_a(2'b11, 0, 0, 1, 132, 1, 0);
    move_a(2'b01, 0, 0, 0, 131, 1, 0);
    move_a(2'b00, 0, 0, 0, 130, 1, 0);
    move_a(2'b10, 0, 0, 0, 129, 1, 0);
    move_a(2'b11, 0, 0, 0, 128, 1, 0);

    // Short glitch on A is filtered out
    @(posedge clk); #1 ea_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 ea_a = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("glitch_pos", pos_a, 128);
    chk("quiet_active", active_a, 0);

    // Illegal 11 -> 00 jump
    move_a(2'b00, 1, 0, 0, 128, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_active", active_a, 0);
    chk("err_pos", pos_a, 128);

    // Wrapping instance: 254 -> 255 -> 0 -> 1 -> 0 -> 255 -> 254
    move_b(2'b10, 1, 255);
    move_b(2'b00, 1, 0);
    move_b(2'b01, 1, 1);
    move_b(2'b00, 0, 0);
    move_b(2'b10, 0, 255);
    move_b(2'b11, 0, 254);

    // Clamp instance: climb to 254, then three more ups against the top bound
    for (int i = 1; i <= 126; i++)
      move_a(up_seq[i % 4], 0, 0, 1, 8'(128 + i), 1, 0);
    move_a(up_seq[3], 0, 0, 1, 255, 1, 0);
    move_a(up_seq[0], 0, 1, 1, 255, 1, 0);
    move_a(up_seq[1], 0, 1, 1, 255, 1, 0);

    // clr lands on the same edge as a clamped up step
    move_a(up_seq[2], 0, 1, 1, 128, 1, 1);
    @(posedge clk); #1 clr_a = 1'b0;
    while (cyc < s_cyc + 49) @(negedge clk);
    chk("active_hold", active_a, 1);
    @(negedge clk);
    chk("active_drop", active_a, 0);
    chk("clr_pos", pos_a, 128);

    // Asynchronous reset mid-cycle, then re-prime from a different level
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_pos", pos_a, 128);
    chk("rst_dir", dir_a, 0);
    chk("rst_active", active_a, 0);
    chk("rst_posw", pos_b, 254);
    {ea_a, ea_b} = 2'b10;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("reprime_pos", pos_a, 128);
    move_a(2'b00, 0, 0, 1, 129, 1, 0);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
